// File: rtl/motor_dir_seq.sv
// motor_dir_seq: H-bridge direction sequencer.
// Accepts forward/reverse/stop commands and guarantees that the bridge is held
// at stop for DEAD_CYCLES clock cycles before any change out of motion, so a
// direct forward<->reverse swap can never reach the bridge.
// Optional command-silence watchdog: define MOTOR_DIR_SEQ_WATCHDOG_EN to build
// it. When the macro is undefined, wdog_trip is tied low and RUN holds
// indefinitely.
module motor_dir_seq #(
    parameter int DEAD_CYCLES = 100000,
    parameter int WDOG_CYCLES = 50000000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_dir,
    output logic       cmd_ready,
    output logic [1:0] dir_out,
    output logic       busy,
    output logic       wdog_trip
);

    localparam logic [1:0] ST_STOP = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DEAD = 2'd2;

    localparam logic [1:0] DIR_FWD  = 2'b00;
    localparam logic [1:0] DIR_STOP = 2'b10;

    // Counter reload value; the DEAD state lasts reload+1 cycles.
    localparam logic [23:0] DEAD_LOAD = 24'(DEAD_CYCLES - 1);

    // Parameters outside their legal range leave a marker block in the hierarchy.
    if (DEAD_CYCLES < 1 || DEAD_CYCLES > 24'hFFFFFF) begin : g_illegal_dead_cycles
    end
    if (WDOG_CYCLES < 1) begin : g_illegal_wdog_cycles
    end

    logic [1:0]  state_reg, state_next;
    logic [1:0]  cur_dir_reg, cur_dir_next;
    logic [1:0]  tgt_dir_reg, tgt_dir_next;
    logic [23:0] dead_cnt_reg, dead_cnt_next;
    logic [1:0]  dir_out_reg, dir_out_next;
    logic        cmd_ready_reg;
    logic        busy_reg;

    logic        accept;
    logic [1:0]  cmd_norm;
    logic        wdog_hit;

    // Handshake depends on state only; 11 is folded onto the stop code.
    assign accept   = cmd_valid && (state_reg != ST_DEAD);
    assign cmd_norm = cmd_dir[1] ? DIR_STOP : cmd_dir;

    // Next-state logic for the direction sequencer.
    always_comb begin
        state_next    = state_reg;
        cur_dir_next  = cur_dir_reg;
        tgt_dir_next  = tgt_dir_reg;
        dead_cnt_next = dead_cnt_reg;
        dir_out_next  = dir_out_reg;
        case (state_reg)
            ST_STOP: begin
                if (accept && !cmd_norm[1]) begin
                    state_next   = ST_RUN;
                    cur_dir_next = cmd_norm;
                    dir_out_next = cmd_norm;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    // Re-issuing the current direction is a no-op.
                    if (cmd_norm != cur_dir_reg) begin
                        state_next    = ST_DEAD;
                        tgt_dir_next  = cmd_norm;
                        cur_dir_next  = DIR_STOP;
                        dir_out_next  = DIR_STOP;
                        dead_cnt_next = DEAD_LOAD;
                    end
                end else if (wdog_hit) begin
                    // Silence timeout behaves exactly like an accepted stop.
                    state_next    = ST_DEAD;
                    tgt_dir_next  = DIR_STOP;
                    cur_dir_next  = DIR_STOP;
                    dir_out_next  = DIR_STOP;
                    dead_cnt_next = DEAD_LOAD;
                end
            end
            ST_DEAD: begin
                if (dead_cnt_reg == 24'd0) begin
                    cur_dir_next = tgt_dir_reg;
                    dir_out_next = tgt_dir_reg;
                    state_next   = tgt_dir_reg[1] ? ST_STOP : ST_RUN;
                end else begin
                    dead_cnt_next = dead_cnt_reg - 24'd1;
                end
            end
            default: begin
                state_next   = ST_STOP;
                cur_dir_next = DIR_STOP;
                dir_out_next = DIR_STOP;
            end
        endcase
    end

    // State and output registers; reset aborts any pending target.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg     <= ST_STOP;
            cur_dir_reg   <= DIR_STOP;
            tgt_dir_reg   <= DIR_STOP;
            dead_cnt_reg  <= 24'd0;
            dir_out_reg   <= DIR_STOP;
            cmd_ready_reg <= 1'b1;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cur_dir_reg   <= cur_dir_next;
            tgt_dir_reg   <= tgt_dir_next;
            dead_cnt_reg  <= dead_cnt_next;
            dir_out_reg   <= dir_out_next;
            cmd_ready_reg <= (state_next != ST_DEAD);
            busy_reg      <= (state_next == ST_DEAD);
        end
    end

`ifdef MOTOR_DIR_SEQ_WATCHDOG_EN
    localparam logic [25:0] WDOG_LAST = 26'(WDOG_CYCLES - 1);

    logic [25:0] silence_reg;
    logic        wdog_trip_reg;
    logic        trip_next;

    assign wdog_hit  = (silence_reg == WDOG_LAST);
    assign trip_next = (state_reg == ST_RUN) && !accept && wdog_hit;

    // Silence counter runs only while in RUN with no command being accepted.
    always_ff @(posedge CLK) begin
        if (RST) begin
            silence_reg   <= 26'd0;
            wdog_trip_reg <= 1'b0;
        end else begin
            wdog_trip_reg <= trip_next;
            if (state_reg != ST_RUN || accept || state_next != ST_RUN) begin
                silence_reg <= 26'd0;
            end else begin
                silence_reg <= silence_reg + 26'd1;
            end
        end
    end

    assign wdog_trip = wdog_trip_reg;
`else
    assign wdog_hit  = 1'b0;
    assign wdog_trip = 1'b0;
`endif

    assign cmd_ready = cmd_ready_reg;
    assign dir_out   = dir_out_reg;
    assign busy      = busy_reg;

    // Forward code is referenced here so its meaning sits next to the stop code.
    logic unused_fwd;
    assign unused_fwd = (DIR_FWD == 2'b00);

endmodule

// File: doc/motor_dir_seq.md
MOTOR_DIR_SEQ -- requirements
Module: motor_dir_seq

Interface
REQ-001 Parameter DEAD_CYCLES, default 100000: dead-time in CLK cycles; H-bridge held at stop before any change out of motion; legal range 1..2^24-1.
REQ-002 Parameter WDOG_CYCLES, default 50000000: command-silence limit in CLK cycles; used only when WATCHDOG_EN is defined.
REQ-003 CLK  input  1  single system clock; all logic on posedge CLK.
REQ-004 RST  input  1  synchronous, active-high reset.
REQ-005 cmd_valid  input  1  requester presents a direction command.
REQ-006 cmd_dir  input  2  requested direction: 00 forward, 01 reverse, 10/11 stop.
REQ-007 cmd_ready  output  1  command accepted on a cycle where cmd_valid and cmd_ready are both high.
REQ-008 dir_out  output  2  registered code to the downstream direction decoder: 00 forward, 01 reverse, 10 stop; 11 never driven.
REQ-009 busy  output  1  high while a dead-time interval is counting.
REQ-010 wdog_trip  output  1  one-cycle pulse when the watchdog forces a stop.

Function
REQ-011 cmd_dir 11 SHALL be normalised to 10 on acceptance.
REQ-012 FSM states: STOP, RUN, DEAD; registers cur_dir (00/01/10), tgt_dir, 24-bit dead counter.
REQ-013 cmd_ready SHALL be 1 in STOP and RUN, 0 in DEAD; commands presented during DEAD are neither stored nor acknowledged.
REQ-014 STOP, accepted 00/01: next cycle dir_out = command, state RUN (latency 1).
REQ-015 STOP, accepted stop: no change.
REQ-016 RUN, accepted command equal to cur_dir: no change; dir_out stays constant, no glitch.
REQ-017 RUN, accepted command different from cur_dir (opposite or stop): next cycle dir_out = 10, tgt_dir = command, counter = DEAD_CYCLES-1, state DEAD.
REQ-018 DEAD: counter decrements each cycle; dir_out held at 10; at the cycle the counter is 0, next cycle dir_out = tgt_dir, cmd_ready = 1, state RUN if tgt_dir is 00/01, else STOP.
REQ-019 dir_out SHALL remain exactly 10 for DEAD_CYCLES consecutive cycles between any two distinct motion codes; a direct 00<->01 transition SHALL never occur.
REQ-020 busy SHALL equal (state == DEAD).
REQ-021 All outputs registered; no combinational path from cmd_valid/cmd_dir to any output except none (cmd_ready depends on state only).

Reset
REQ-022 RST high on a CLK edge: state STOP, dir_out 10, cur_dir 10, tgt_dir 10, counters 0, busy 0, wdog_trip 0, cmd_ready 1 the following cycle.
REQ-023 RST asserted mid-DEAD or mid-RUN SHALL abort immediately to the reset state; the pending target is discarded.
REQ-024 RST has priority over cmd_valid on the same edge.

Configuration
REQ-025 Macro MOTOR_DIR_SEQ_WATCHDOG_EN defined: a 26-bit silence counter clears on every accepted command and on leaving RUN; in RUN, when it reaches WDOG_CYCLES-1, next cycle wdog_trip = 1 for one cycle and the block behaves exactly as if stop were accepted (REQ-017).
REQ-026 Watchdog trip and an accepted command on the same cycle: the accepted command wins, counter clears, no trip.
REQ-027 Macro not defined: no silence counter is built, wdog_trip is tied to 0, RUN holds indefinitely.

Verification (DEAD_CYCLES=4, WDOG_CYCLES=20)
REQ-028 Reset, then cmd 00 accepted at cycle 0 -> dir_out 00 at cycle 1, busy 0, cmd_ready 1.
REQ-029 RUN 00, cmd 01 accepted at cycle t -> dir_out 10 and busy 1 for cycles t+1..t+4, dir_out 01 at t+5, cmd_ready 0 during t+1..t+4.
REQ-030 cmd 00 presented during DEAD toward 01 -> not acknowledged; final dir_out 01; re-presented 00 afterwards -> second 4-cycle dead interval.
REQ-031 RST asserted at 2nd cycle of DEAD -> next cycle dir_out 10, state STOP, busy 0; subsequent cmd 01 -> dir_out 01 after 1 cycle.
REQ-032 WATCHDOG_EN, RUN 01 with no commands for 20 cycles -> wdog_trip single pulse, dir_out 10 for 4 cycles then stays 10 in STOP; without macro -> dir_out stays 01, wdog_trip always 0.
REQ-033 RUN 00, cmd 11 accepted -> treated as stop: 4 cycles dead, then STOP with dir_out 10.
